// File: rtl/addsub_nibble_sched.sv
// Two-port round-robin scheduler around a single 4-bit add/subtract slice.
// Each accepted operation is iterated LSB nibble first with a registered carry chain.
`timescale 1ns/1ps

module addsub_nibble_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_sub,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_sub,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_data,
    output logic                 rsp_cout,
    output logic                 rsp_id,

    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic          sub_q, sub_d;
    logic          id_q, id_d;
    logic          last_grant_q, last_grant_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_id_q, rsp_id_d;

    logic          grant0;
    logic          grant1;
    logic [IW+1:0] nib_off;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic          slice_cin;
    logic [4:0]    slice_sum;
    logic [W-1:0]  res_merged;

    // Contested grants go to the requester that did not win last time.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    // Shared slice: b is conditionally inverted, cin seeds the chain with the sub flag.
    assign nib_off    = {idx_q, 2'b00};
    assign a_nib      = 4'(a_q >> nib_off);
    assign b_nib      = 4'(b_q >> nib_off) ^ {4{sub_q}};
    assign slice_cin  = (idx_q == '0) ? sub_q : carry_q;
    assign slice_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, slice_cin};
    assign res_merged = (res_q & ~(W'(4'hF) << nib_off)) | (W'(slice_sum[3:0]) << nib_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            sub_q        <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            sub_q        <= sub_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // Valid/ready: a transfer happens on a rising edge where both are high; a requester
    // may drop valid while ready is low, and ready never depends on a registered handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        sub_d        = sub_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_id_d     = rsp_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    sub_d        = grant1 ? req1_sub : req0_sub;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    idx_d        = '0;
                    carry_d      = 1'b0;
                    res_d        = '0;
                    state_d      = S_CALC;
                end
            end

            S_CALC: begin
                res_d   = res_merged;
                carry_d = slice_sum[4];
                if (idx_q == IDX_LAST) begin
                    rsp_data_d = res_merged;
                    rsp_cout_d = slice_sum[4];
                    rsp_id_d   = id_q;
                    idx_d      = '0;
                    state_d    = S_RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_nibble_sched.sv
// Bench for addsub_nibble_sched: arithmetic reference model feeding an expected-response
// queue, a cycle-level grant/timing model, directed corner cases and a random phase.
`timescale 1ns/1ps

module tb_addsub_nibble_sched;

    localparam int N  = 4;
    localparam int W  = 4 * N;
    localparam int RW = W + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_sub = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_sub = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_data;
    logic         rsp_cout;
    logic         rsp_id;
    logic         busy;
    logic [1:0]   dbg_state;

    logic [RW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    addsub_nibble_sched #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] ref_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub, input logic id);
        logic [W:0] s;
        logic       c;
        if (sub) begin
            s = {1'b0, a} - {1'b0, b};
            c = (a >= b);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            c = s[W];
        end
        return {id, c, s[W-1:0]};
    endfunction

    // ---------------- grant / timing model (pushes expected responses) ----------------
    bit m_idle = 1'b1;
    bit m_last = 1'b1;
    int m_cnt  = 0;

    always @(negedge clk) begin : issue_model
        logic e0, e1, ev;
        if (rst) begin
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_state", dbg_state, 2'd0);
            m_idle = 1'b1;
            m_last = 1'b1;
            m_cnt  = 0;
        end else begin
            e0 = m_idle && req0_valid && (!req1_valid || m_last);
            e1 = m_idle && req1_valid && (!req0_valid || !m_last);
            ev = !m_idle && (m_cnt >= N + 1);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("rsp_valid", rsp_valid, ev);
            chk("busy", busy, !m_idle);
            if (e0) begin
                exp_q.push_back(ref_rsp(req0_a, req0_b, req0_sub, 1'b0));
                m_last = 1'b0;
                m_idle = 1'b0;
                m_cnt  = 1;
            end else if (e1) begin
                exp_q.push_back(ref_rsp(req1_a, req1_b, req1_sub, 1'b1));
                m_last = 1'b1;
                m_idle = 1'b0;
                m_cnt  = 1;
            end else if (!m_idle) begin
                if (ev && rsp_ready) m_idle = 1'b1;
                else m_cnt++;
            end
        end
    end

    // ---------------- response scoreboard ----------------
    logic [RW-1:0] last_rsp = '0;

    always @(negedge clk) begin : rsp_monitor
        if (rst) begin
            exp_q.delete();
            last_rsp = '0;
            chk("rst_rsp_fields", {rsp_id, rsp_cout, rsp_data}, '0);
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got data 0x%0h with no expected entry at %0t",
                         rsp_data, $time);
            end else begin
                chk("rsp_data", rsp_data, exp_q[0][W-1:0]);
                chk("rsp_cout", rsp_cout, exp_q[0][W]);
                chk("rsp_id", rsp_id, exp_q[0][W+1]);
                if (rsp_ready) last_rsp = exp_q.pop_front();
            end
        end else if (!busy) begin
            chk("rsp_hold", {rsp_id, rsp_cout, rsp_data}, last_rsp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("accept_seen", seen, 1'b1);
        @(posedge clk); #1;
        // Scramble operands right after acceptance; the result must not change.
        if (p == 0) begin
            req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
        end else begin
            req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
        end
    endtask

    task automatic expect_rsp(input logic [W-1:0] d, input logic c, input logic id,
                              input int lat);
        bit seen = 1'b0;
        int k    = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                k    = i;
                break;
            end
        end
        chk("rsp_seen", seen, 1'b1);
        if (lat > 0) chk("rsp_latency", k, lat);
        chk("dir_data", rsp_data, d);
        chk("dir_cout", rsp_cout, c);
        chk("dir_id", rsp_id, id);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_reached", done, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int g_id[4];
    int g_cyc[4];
    int ng;
    bit bp_seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Add, latency from accept edge to rsp_valid is NIBBLES+1 cycles.
        issue(0, 16'h1234, 16'h0FFF, 1'b0);
        expect_rsp(16'h2233, 1'b0, 1'b0, N + 1);

        // Subtract with and without borrow.
        issue(1, 16'h0005, 16'h0007, 1'b1);
        expect_rsp(16'hFFFE, 1'b0, 1'b1, 0);
        issue(1, 16'h8000, 16'h0001, 1'b1);
        expect_rsp(16'h7FFF, 1'b1, 1'b1, 0);

        // Wrap-around corners.
        issue(0, 16'hFFFF, 16'h0001, 1'b0);
        expect_rsp(16'h0000, 1'b1, 1'b0, 0);
        issue(1, 16'h0000, 16'h0000, 1'b1);
        expect_rsp(16'h0000, 1'b1, 1'b1, 0);
        wait_idle();

        // Contention: both valid continuously, grants alternate every NIBBLES+2 cycles.
        @(posedge clk); #1;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom); req0_valid = 1'b1;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom); req1_valid = 1'b1;
        ng = 0;
        for (int cyc = 0; cyc < 80 && ng < 4; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                g_id[ng]  = int'(req1_ready);
                g_cyc[ng] = cyc;
                ng++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("grant_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
            chk("grant_id", g_id[i], i % 2);
            if (i > 0) chk("grant_gap", g_cyc[i] - g_cyc[i-1], N + 2);
        end
        wait_idle();

        // Backpressure: hold rsp_ready low for 3 cycles with req0 waiting.
        rsp_ready = 1'b0;
        issue(1, 16'hABCD, 16'h1234, 1'b0);
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'b1; req0_valid = 1'b1;
        bp_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                bp_seen = 1'b1;
                break;
            end
        end
        chk("bp_rsp_seen", bp_seen, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_data", rsp_data, 16'hBE01);
            chk("bp_cout", rsp_cout, 1'b0);
            chk("bp_id", rsp_id, 1'b1);
            chk("bp_busy", busy, 1'b1);
            chk("bp_readies", {req0_ready, req1_ready}, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_until_handshake", rsp_valid, 1'b1);
        @(negedge clk);
        chk("bp_handshake_done", rsp_valid, 1'b0);
        chk("bp_next_accept", req0_ready, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_idle();

        // Reset while CALC works on nibble 2.
        issue(0, W'($urandom), W'($urandom), 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        issue(0, 16'h0001, 16'h0001, 1'b0);
        expect_rsp(16'h0002, 1'b0, 1'b0, N + 1);
        wait_idle();

        // Random traffic with random backpressure and withdrawals.
        repeat (600) begin
            @(posedge clk); #1;
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            req0_b     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            req0_sub   = 1'($urandom);
            req1_a     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            req1_b     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            req1_sub   = 1'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_nibble_sched.md
# addsub_nibble_sched

Sequencer and arbiter that shares one 4-bit add/subtract slice between two requesters. The block performs NIBBLES×4-bit add or subtract operations by iterating the slice one nibble per cycle, LSB first, and chains the carry through a register. It sits between two client ports, each with a valid/ready request channel, and a single valid/ready response channel. Grants use round-robin arbitration.

## Interface
Parameters:
- NIBBLES, default 4: operand width in nibbles. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  W  operand A, requester 0.
- req0_b  in  W  operand B, requester 0.
- req0_sub  in  1  1 = A−B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as above, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  W  result, modulo 2^W.
- rsp_cout  out  1  final carry-out. For sub, 1 means no borrow (A ≥ B, unsigned).
- rsp_id  out  1  requester that issued this result.
- busy  out  1  high in CALC or RESP.

## Operation
- Internal datapath is one 4-bit slice. Inputs: a nibble, b nibble, invert_b, cin. Outputs: sum nibble, cout. b is XORed with invert_b; then A + b' + cin is formed.
- invert_b equals the latched sub flag for every nibble.
- cin equals the sub flag for nibble 0 only. For nibble 1..NIBBLES−1, cin equals the registered carry from the previous nibble.
- FSM states:
  - IDLE: arbitrate. When a grant is given, latch A, B, sub and id. Go to CALC with nibble index 0.
  - CALC: each cycle, compute nibble idx, write its sum into result bits [4idx+3:4idx] and register the carry. idx increments by 1. After idx = NIBBLES−1, latch the final carry as rsp_cout and go to RESP.
  - RESP: hold rsp_valid=1. When rsp_ready=1, go to IDLE.
- Arbitration happens only in IDLE. A one-bit last_grant pointer is used.
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates on every grant.
- reqX_ready is combinational: 1 only in IDLE and only for the granted requester. At most one ready is high per cycle. Both readies are 0 outside IDLE.
- Request operands are sampled only on the accept edge. Later changes on req inputs do not affect the operation in progress.
- rsp_data, rsp_cout and rsp_id are stable throughout RESP. They keep their last value in IDLE.
- No back-to-back acceptance: a new request is accepted only after the response handshake completes and the FSM has returned to IDLE.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state = IDLE, idx = 0, carry = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_cout = 0, rsp_id = 0, busy = 0.
  - last_grant = 1, so requester 0 wins the first contested grant.
  - req0_ready and req1_ready follow from IDLE and the current valids.
- Accept on edge T. CALC runs for cycles T+1 .. T+NIBBLES. rsp_valid is high from cycle T+NIBBLES+1.
- Minimum issue interval is NIBBLES+2 cycles: accept, NIBBLES calc cycles, one RESP cycle with rsp_ready=1.
- rsp_ready held low stalls the block in RESP indefinitely. No request is accepted while stalled.
- rst asserted mid-CALC or in RESP aborts the operation. No response is produced for the aborted request. After rst deasserts, the first valid request is accepted on the first edge.
- The requester withdraws by dropping valid while ready=0. This is legal, and no state changes.
- Simultaneous valid on both ports in the cycle after a completed response: the grant goes to the non-last_grant requester.

## Test plan
- Add (NIBBLES=4): req0 A=0x1234, B=0x0FFF, sub=0.
  - Expect req0_ready=1 in the accept cycle.
  - Expect rsp_valid exactly 5 cycles later with rsp_data=0x2233, rsp_cout=0, rsp_id=0.
- Subtract: req1 issues 0x0005−0x0007, then 0x8000−0x0001.
  - First result: rsp_data=0xFFFE, rsp_cout=0.
  - Second result: rsp_data=0x7FFF, rsp_cout=1.
  - rsp_id=1 for both.
- Wrap: 0xFFFF+0x0001 gives rsp_data=0x0000, rsp_cout=1. 0x0000−0x0000 gives 0x0000, rsp_cout=1.
- Contention: both valid continuously with rsp_ready=1. Expect rsp_id sequence 0,1,0,1, and each grant spaced 6 cycles apart.
- Backpressure: rsp_ready=0 for 3 cycles after rsp_valid rises.
  - Expect rsp_data, rsp_cout and rsp_id unchanged, busy=1, and both readies 0.
  - Expect the completion handshake on the cycle rsp_ready rises.
- Reset mid-operation: assert rst during CALC idx=2.
  - Expect rsp_valid=0 and busy=0 immediately.
  - After release, req0 0x0001+0x0001 returns 0x0002 with rsp_id=0.
